// File: rtl/la_ppv_recv_pkg.sv
// Shared look-ahead PPV definitions: router geometry, slot-to-slice mapping, FIFO occupancy encoding.
package la_ppv_recv_pkg;

  localparam int LA_NUM_PORT   = 5;
  localparam int LA_FLIT_WIDTH = 32;
  localparam int LA_NUM_SLOT   = 4;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  // Slot 0 occupies the MSBs of the look-ahead vector.
  function automatic int slice_msb(input int slot, input int num_port);
    return num_port * (LA_NUM_SLOT - slot) - 1;
  endfunction

endpackage

// File: rtl/ppv_slot_sel.sv
// Picks this router's PPV slice by allocator slot and flags malformed vectors.
// Purely combinational, no backpressure involvement.
module ppv_slot_sel
  import la_ppv_recv_pkg::*;
#(
  parameter int NUM_PORT = LA_NUM_PORT
) (
  input  logic [LA_NUM_SLOT*NUM_PORT-1:0] next_ppv,
  input  logic [1:0]                      slot,
  input  logic                            mc,
  output logic [NUM_PORT-1:0]             ppv,
  output logic                            malformed
);

  localparam logic [NUM_PORT-1:0] PPV_ONE = NUM_PORT'(1);

  always_comb begin
    ppv = '0;
    for (int s = 0; s < LA_NUM_SLOT; s++) begin
      if (slot == 2'(s)) ppv = next_ppv[slice_msb(s, NUM_PORT) -: NUM_PORT];
    end
  end

  // Unicast must be exactly one-hot; multicast only needs at least one port.
  assign malformed = (ppv == '0) || (!mc && ((ppv & (ppv - PPV_ONE)) != '0));

endmodule

// File: rtl/la_ppv_recv.sv
// Look-ahead PPV receiver: 2-entry FIFO holding flit, mc flag and the selected PPV slice; 1-cycle in->out.
// in_ready is registered from occupancy only (low when FULL), never from out_ready.
module la_ppv_recv
  import la_ppv_recv_pkg::*;
#(
  parameter int NUM_PORT   = LA_NUM_PORT,
  parameter int FLIT_WIDTH = LA_FLIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_mc,
  input  logic [4*NUM_PORT-1:0] in_next_ppv,
  input  logic [1:0]            in_slot,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_mc,
  output logic [NUM_PORT-1:0]   out_ppv,
  input  logic                  out_ready,
  output logic                  err_pulse,
  output logic [7:0]            err_cnt,
  output logic [15:0]           flit_cnt
);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] flit;
    logic                  mc;
    logic [NUM_PORT-1:0]   ppv;
  } entry_t;

  fifo_state_t         state, state_nxt;
  entry_t              head, tail, in_entry;
  logic                push, pop;
  logic [NUM_PORT-1:0] sel_ppv;
  logic                sel_malformed;

  ppv_slot_sel #(.NUM_PORT(NUM_PORT)) u_slot_sel (
    .next_ppv  (in_next_ppv),
    .slot      (in_slot),
    .mc        (in_mc),
    .ppv       (sel_ppv),
    .malformed (sel_malformed)
  );

  assign in_entry  = '{flit: in_flit, mc: in_mc, ppv: sel_ppv};
  assign push      = in_valid && in_ready;
  assign out_valid = (state != FIFO_EMPTY);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FIFO_EMPTY: if (push) state_nxt = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_nxt = FIFO_FULL;
        else if (pop && !push) state_nxt = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_nxt = FIFO_ONE;
      default:    state_nxt = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FIFO_EMPTY;
      in_ready  <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
      flit_cnt  <= 16'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FIFO_FULL);
      err_pulse <= push && sel_malformed;
      if (push && sel_malformed && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (pop) flit_cnt <= flit_cnt + 16'd1;
    end
  end

  // Head is the output register; tail only fills when a push lands on a non-draining ONE.
  always_ff @(posedge clk) begin
    if (push && ((state == FIFO_EMPTY) || ((state == FIFO_ONE) && pop))) head <= in_entry;
    else if (pop && (state == FIFO_FULL))                                head <= tail;
    if (push && (state == FIFO_ONE) && !pop) tail <= in_entry;
  end

  assign out_flit = head.flit;
  assign out_mc   = head.mc;
  assign out_ppv  = out_valid ? head.ppv : '0;

endmodule

// File: tb/tb_la_ppv_recv.sv
// Directed bench for la_ppv_recv with a queue-based reference model checked every cycle.
module tb_la_ppv_recv;
  import la_ppv_recv_pkg::*;

  localparam int NP = LA_NUM_PORT;
  localparam int FW = LA_FLIT_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_mc, in_ready, out_valid, out_mc, out_ready, err_pulse;
  logic [FW-1:0] in_flit, out_flit;
  logic [4*NP-1:0] in_next_ppv;
  logic [1:0]    in_slot;
  logic [NP-1:0] out_ppv;
  logic [7:0]    err_cnt;
  logic [15:0]   flit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  la_ppv_recv #(.NUM_PORT(NP), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_flit(in_flit), .in_mc(in_mc),
    .in_next_ppv(in_next_ppv), .in_slot(in_slot), .in_ready(in_ready), .out_valid(out_valid),
    .out_flit(out_flit), .out_mc(out_mc), .out_ppv(out_ppv), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted flits plus plain integer counters.
  typedef struct {
    logic [FW-1:0] flit;
    logic          mc;
    logic [NP-1:0] ppv;
  } ent_t;

  ent_t mq[$];
  bit   m_rdy;
  bit   m_err;
  int   m_errs;
  int   m_flits;

  function automatic logic [NP-1:0] pick(input logic [4*NP-1:0] v, input logic [1:0] slot);
    return NP'(v >> (NP * (3 - int'(slot))));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit            do_push, do_pop;
    logic [NP-1:0] s;
    ent_t          e;
    if (!reset_n) begin
      mq.delete();
      m_rdy = 0; m_err = 0; m_errs = 0; m_flits = 0;
    end else begin
      do_push = in_valid && m_rdy;
      do_pop  = (mq.size() > 0) && out_ready;
      m_err   = 0;
      if (do_pop) begin
        void'(mq.pop_front());
        m_flits = (m_flits + 1) % 65536;
      end
      if (do_push) begin
        s = pick(in_next_ppv, in_slot);
        e.flit = in_flit; e.mc = in_mc; e.ppv = s;
        mq.push_back(e);
        if (s == '0 || (!in_mc && $countones(s) > 1)) begin
          m_err = 1;
          if (m_errs < 255) m_errs++;
        end
      end
      m_rdy = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_flit", 32'(out_flit), 32'(mq[0].flit));
      chk("out_mc", 32'(out_mc), 32'(mq[0].mc));
      chk("out_ppv", 32'(out_ppv), 32'(mq[0].ppv));
    end else begin
      chk("out_ppv_idle", 32'(out_ppv), 32'd0);
    end
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    chk("flit_cnt", 32'(flit_cnt), 32'(m_flits));
  end

  task automatic step(input bit v, input logic [FW-1:0] f, input bit mc,
                      input logic [4*NP-1:0] pv, input logic [1:0] sl, input bit ordy);
    in_valid = v; in_flit = f; in_mc = mc; in_next_ppv = pv; in_slot = sl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 1'b0, '0, 2'd0, ordy);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_flit = '0; in_mc = 1'b0; in_next_ppv = '0; in_slot = 2'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ppv", 32'(out_ppv), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_flit_cnt", 32'(flit_cnt), 32'd0);
    reset_n = 1'b1;
    idle(1'b1);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // Slice 2 = bits 9:5; 20'h00040 puts 5'b00010 there.
    step(1'b1, 32'hA1, 1'b0, 20'h00040, 2'd2, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_ppv", 32'(out_ppv), 32'b00010);
    chk("t1_err", 32'(err_pulse), 32'd0);
    idle(1'b1);
    chk("t1_flit_cnt", 32'(flit_cnt), 32'd1);
    chk("t1_ppv_idle", 32'(out_ppv), 32'd0);
    step(1'b1, 32'hA2, 1'b0, 20'h00400, 2'd1, 1'b1);
    chk("t1b_ppv", 32'(out_ppv), 32'b00001);
    idle(1'b1);

    // Fill to FULL with a stalled consumer, then drain and admit the held flit.
    step(1'b1, 32'hB1, 1'b0, 20'h08000, 2'd0, 1'b0);
    chk("t2_rdy1", 32'(in_ready), 32'd1);
    step(1'b1, 32'hB2, 1'b0, 20'h00001, 2'd3, 1'b0);
    chk("t2_full_rdy", 32'(in_ready), 32'd0);
    step(1'b1, 32'hB3, 1'b0, 20'h00020, 2'd2, 1'b0);
    chk("t2_held_rdy", 32'(in_ready), 32'd0);
    chk("t2_head_b1", 32'(out_flit), 32'hB1);
    step(1'b1, 32'hB3, 1'b0, 20'h00020, 2'd2, 1'b1);
    chk("t2_head_b2", 32'(out_flit), 32'hB2);
    chk("t2_rdy_one", 32'(in_ready), 32'd1);
    step(1'b1, 32'hB3, 1'b0, 20'h00020, 2'd2, 1'b1);
    chk("t2_head_b3", 32'(out_flit), 32'hB3);
    idle(1'b1);
    chk("t2_flit_cnt", 32'(flit_cnt), 32'd5);
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Malformed detection: empty unicast slice, multi-hot unicast, multi-hot multicast.
    step(1'b1, 32'hC1, 1'b0, 20'h07FFF, 2'd0, 1'b1);
    chk("t3_err1", 32'(err_pulse), 32'd1);
    chk("t3_cnt1", 32'(err_cnt), 32'd1);
    chk("t3_flit1", 32'(out_flit), 32'hC1);
    step(1'b1, 32'hC2, 1'b0, 20'hFFFF4, 2'd3, 1'b1);
    chk("t3_err2", 32'(err_pulse), 32'd1);
    chk("t3_cnt2", 32'(err_cnt), 32'd2);
    chk("t3_ppv2", 32'(out_ppv), 32'b10100);
    step(1'b1, 32'hC3, 1'b1, 20'h05000, 2'd1, 1'b1);
    chk("t3_mc_noerr", 32'(err_pulse), 32'd0);
    chk("t3_cnt3", 32'(err_cnt), 32'd2);
    chk("t3_ppv3", 32'(out_ppv), 32'b10100);
    idle(1'b1);
    chk("t3_flit_cnt", 32'(flit_cnt), 32'd8);

    // Reset asserted mid-cycle while FULL.
    step(1'b1, 32'hD1, 1'b0, 20'h08000, 2'd0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 20'h08000, 2'd0, 1'b0);
    chk("t4_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_ready", 32'(in_ready), 32'd0);
    chk("t4_rst_flits", 32'(flit_cnt), 32'd0);
    chk("t4_rst_errs", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1'b1);
    chk("t4_rdy_back", 32'(in_ready), 32'd1);
    chk("t4_no_stale", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("t4_no_stale2", 32'(out_valid), 32'd0);

    // Continuous push/pop through ONE until flit_cnt wraps.
    for (int i = 0; i < 65537; i++) step(1'b1, FW'(i), 1'b0, 20'h08000, 2'd0, 1'b1);
    chk("t5_wrap0", 32'(flit_cnt), 32'd0);
    idle(1'b1);
    chk("t5_wrap1", 32'(flit_cnt), 32'd1);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) step(1'b1, FW'(i), 1'b0, 20'h00000, 2'd2, 1'b1);
    chk("t6_sat_pulse", 32'(err_pulse), 32'd1);
    chk("t6_sat_cnt", 32'(err_cnt), 32'd255);
    idle(1'b1);
    chk("t6_flits", 32'(flit_cnt), 32'd301);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
